alu_flag_unit: RTL
==================

Name: alu_flag_unit

Overview:
Parametrised, registered successor to the ALU result/flag mux. It selects the adder, logic or shifter result by opcode and computes N/Z/C/V from the selected result in the same cycle. Result and flags are registered behind a one-entry valid/ready output stage. It adds a flag-write enable, a sticky overflow bit and a saturating overflow-event counter. It sits between the ALU datapath units and the register-file write-back / branch logic.

Parameters:
WIDTH, 8, datapath width of all result buses.
CNT_W, 8, width of the saturating overflow-event counter.

Ports:
clk  input  1  system clock; all state on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operation presented this cycle.
in_ready  output  1  unit can accept an operation this cycle.
op  input  3  opcode selecting the result source.
y_logic  input  WIDTH  logic unit result.
y_shift  input  WIDTH  shifter result.
y_add  input  WIDTH  adder result.
c_add  input  1  adder carry-out.
c_shift  input  1  shifter carry-out (last bit shifted out).
v_add  input  1  adder signed overflow.
flag_we  input  1  update N/Z/C/V on acceptance.
sticky_clr  input  1  clear v_sticky and ovf_count.
out_valid  output  1  registered result available.
out_ready  input  1  consumer takes the result this cycle.
y  output  WIDTH  registered selected result.
n, z, c, v  output  1 each  registered architectural flags.
v_sticky  output  1  sticky overflow.
ovf_count  output  CNT_W  saturating count of accepted overflows.

Behaviour:
- Reset (rst=1 at clock edge): y=0, n=z=c=v=0, v_sticky=0, ovf_count=0, out_valid=0. Reset overrides all other inputs, including a transfer in flight; any pending output is discarded.
- Source select (combinational):
  - op[2:1]=00 (000, 001): adder; sel_y=y_add, sel_c=c_add, sel_v=v_add.
  - op=101 or 110: logic; sel_y=y_logic, sel_c=0, sel_v=0.
  - All other opcodes (010, 011, 100, 111): shifter; sel_y=y_shift, sel_c=c_shift, sel_v=0.
- Flag values: sel_n=sel_y[WIDTH-1]; sel_z=(sel_y==0). Both come from the newly selected value, never from the registered y.
- Handshake:
  - in_ready = !out_valid || out_ready, combinational from out_ready.
  - accept = in_valid && in_ready.
- Latency: 1 cycle. On accept, y<=sel_y and out_valid<=1.
  - Otherwise, if out_ready, out_valid<=0.
  - Otherwise y and out_valid hold.
- Back-to-back: accept with out_ready=1 and out_valid=1 replaces the output with no bubble.
- Flag register:
  - On accept with flag_we=1: n,z,c,v <= sel_n, sel_z, sel_c, sel_v.
  - On accept with flag_we=0: flags hold.
  - Flags never change without an accept.
  - Flags are independent of out_valid: they persist after the result is consumed.
- Overflow event: ovf_evt = accept && flag_we && sel_v.
- v_sticky:
  - Set on ovf_evt.
  - Cleared by sticky_clr when there is no simultaneous ovf_evt.
  - Set wins: ovf_evt and sticky_clr in the same cycle leaves v_sticky=1.
- ovf_count:
  - On ovf_evt && sticky_clr: load 1.
  - On sticky_clr alone: load 0.
  - On ovf_evt alone: increment, saturating at 2^CNT_W-1 with no wrap.
- Stall: while out_valid=1 and out_ready=0, in_ready=0 and all outputs hold, regardless of in_valid or op changes.
- Widths: no internal arithmetic on y. Z uses a full-WIDTH compare. WIDTH>=2 is required.

Decomposition:
- Package alu_pkg holds:
  - opcode constants: OP_ADD0=3'b000, OP_ADD1=3'b001, OP_LOGIC0=3'b101, OP_LOGIC1=3'b110;
  - the source-class enum: SRC_ADD, SRC_LOGIC, SRC_SHIFT;
  - flag index constants: FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One combinational sub-module, alu_result_sel. It takes op, the three results and the carry/overflow inputs, and produces sel_y, sel_n, sel_z, sel_c, sel_v.
- Handshake, flag register, sticky bit and counter stay in alu_flag_unit.

Test Plan:
- Reset mid-stall: out_valid=1, out_ready=0, assert rst -> next cycle out_valid=0, y=0, flags 0, ovf_count=0.
- Adder path, WIDTH=8: op=000, y_add=8'h80, c_add=1, v_add=1, flag_we=1, out_ready=1 -> next cycle y=8'h80, n=1, z=0, c=1, v=1, v_sticky=1, ovf_count=1.
- Logic zero: op=101, y_logic=8'h00, c_add=1, v_add=1 -> y=0, z=1, n=0, c=0, v=0. Repeat with op=110 -> same result.
- Shifter and flag_we: op=011, y_shift=8'h01, c_shift=1, flag_we=0 after previous flags n=1,c=0 -> y=8'h01, flags unchanged (n=1, c=0). Same op with flag_we=1 -> n=0, z=0, c=1, v=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 and changing op/inputs -> in_ready=0, y and flags hold. Raise out_ready -> one accept per cycle thereafter, out_valid continuously 1.
- Counter saturation and clear precedence, CNT_W=2: 5 consecutive overflow accepts -> ovf_count=3. Then sticky_clr with a concurrent overflow accept -> ovf_count=1, v_sticky=1. Then sticky_clr alone -> ovf_count=0, v_sticky=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode constants, source-class enum and flag bit positions for the
// ALU result/flag unit.
package alu_pkg;

  localparam logic [2:0] OP_ADD0   = 3'b000;
  localparam logic [2:0] OP_ADD1   = 3'b001;
  localparam logic [2:0] OP_LOGIC0 = 3'b101;
  localparam logic [2:0] OP_LOGIC1 = 3'b110;

  typedef enum logic [1:0] {
    SRC_ADD,
    SRC_LOGIC,
    SRC_SHIFT
  } src_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Everything that is neither adder nor logic falls to the shifter.
  function automatic src_e op_src(input logic [2:0] op);
    unique case (op)
      OP_ADD0, OP_ADD1:     op_src = SRC_ADD;
      OP_LOGIC0, OP_LOGIC1: op_src = SRC_LOGIC;
      default:              op_src = SRC_SHIFT;
    endcase
  endfunction

endpackage

// File: rtl/alu_result_sel.sv
// Combinational source select plus N/Z/C/V derived from the selected value.
module alu_result_sel
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] y_logic_i,
  input  logic [WIDTH-1:0] y_shift_i,
  input  logic [WIDTH-1:0] y_add_i,
  input  logic             c_add_i,
  input  logic             c_shift_i,
  input  logic             v_add_i,
  output logic [WIDTH-1:0] sel_y_o,
  output logic             sel_n_o,
  output logic             sel_z_o,
  output logic             sel_c_o,
  output logic             sel_v_o
);

  always_comb begin
    sel_y_o = y_shift_i;
    sel_c_o = c_shift_i;
    sel_v_o = 1'b0;
    unique case (op_src(op_i))
      SRC_ADD: begin
        sel_y_o = y_add_i;
        sel_c_o = c_add_i;
        sel_v_o = v_add_i;
      end
      SRC_LOGIC: begin
        sel_y_o = y_logic_i;
        sel_c_o = 1'b0;
      end
      default: ;
    endcase
  end

  assign sel_n_o = sel_y_o[WIDTH-1];
  assign sel_z_o = (sel_y_o == '0);

endmodule

// File: rtl/alu_flag_unit.sv
// Registered ALU result/flag stage: one-entry valid/ready output, flag-write
// enable, sticky overflow and a saturating overflow-event counter.
module alu_flag_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] y_logic,
  input  logic [WIDTH-1:0] y_shift,
  input  logic [WIDTH-1:0] y_add,
  input  logic             c_add,
  input  logic             c_shift,
  input  logic             v_add,
  input  logic             flag_we,
  input  logic             sticky_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             n,
  output logic             z,
  output logic             c,
  output logic             v,
  output logic             v_sticky,
  output logic [CNT_W-1:0] ovf_count
);

  logic [WIDTH-1:0] sel_y;
  logic             sel_n, sel_z, sel_c, sel_v;
  logic             accept, ovf_evt;

  logic [WIDTH-1:0] y_q, y_d;
  logic             vld_q, vld_d;
  logic [3:0]       flags_q, flags_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  alu_result_sel #(.WIDTH(WIDTH)) u_sel (
    .op_i      (op),
    .y_logic_i (y_logic),
    .y_shift_i (y_shift),
    .y_add_i   (y_add),
    .c_add_i   (c_add),
    .c_shift_i (c_shift),
    .v_add_i   (v_add),
    .sel_y_o   (sel_y),
    .sel_n_o   (sel_n),
    .sel_z_o   (sel_z),
    .sel_c_o   (sel_c),
    .sel_v_o   (sel_v)
  );

  assign in_ready = !vld_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign ovf_evt  = accept && flag_we && sel_v;

  always_comb begin
    y_d      = y_q;
    vld_d    = vld_q;
    flags_d  = flags_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;

    if (accept) begin
      y_d   = sel_y;
      vld_d = 1'b1;
    end else if (out_ready) begin
      vld_d = 1'b0;
    end

    if (accept && flag_we) begin
      flags_d[FLAG_N] = sel_n;
      flags_d[FLAG_Z] = sel_z;
      flags_d[FLAG_C] = sel_c;
      flags_d[FLAG_V] = sel_v;
    end

    // A same-cycle overflow beats the clear: the event that just happened is kept.
    if (sticky_clr) begin
      sticky_d = ovf_evt;
      cnt_d    = ovf_evt ? CNT_W'(1) : '0;
    end else if (ovf_evt) begin
      sticky_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q      <= '0;
      vld_q    <= 1'b0;
      flags_q  <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      y_q      <= y_d;
      vld_q    <= vld_d;
      flags_q  <= flags_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign y         = y_q;
  assign out_valid = vld_q;
  assign n         = flags_q[FLAG_N];
  assign z         = flags_q[FLAG_Z];
  assign c         = flags_q[FLAG_C];
  assign v         = flags_q[FLAG_V];
  assign v_sticky  = sticky_q;
  assign ovf_count = cnt_q;

endmodule
